// File: rtl/rom_access_scheduler_pkg.sv
// rtl/rom_access_scheduler_pkg.sv - shared types, constants and CPU address map for the ROM access scheduler
package rom_access_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        READ,
        DONE
    } state_t;

    typedef enum logic {
        CPU,
        DBG
    } grant_t;

    localparam logic [3:0] MOS_BANK     = 4'h4;
    localparam logic [3:0] ROMSEL_RESET = 4'hF;
    localparam logic [7:0] DATA_RESET   = 8'hFF;

    // &C000-&FFFF is always the MOS, &8000-&BFFF the paged bank; below &8000 lands in
    // bank 0, which the ROM set leaves unpopulated so it reads back as &FF.
    function automatic logic [17:0] map_cpu_addr(input logic [15:0] addr, input logic [3:0] sel);
        logic [17:0] mapped;
        case (addr[15:14])
            2'b11:   mapped = {MOS_BANK, addr[13:0]};
            2'b10:   mapped = {sel, addr[13:0]};
            default: mapped = {4'h0, addr[13:0]};
        endcase
        return mapped;
    endfunction

endpackage

// File: rtl/rom_access_scheduler_if.sv
// rtl/rom_access_scheduler_if.sv - CPU, debug, ROMSEL and ROM-set signals of the ROM access scheduler
interface rom_access_scheduler_if;

    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_ack;
    logic [7:0]  cpu_data;
    logic        romsel_we;
    logic [3:0]  romsel_din;
    logic [3:0]  romsel;
    logic        dbg_req;
    logic [17:0] dbg_addr;
    logic        dbg_ack;
    logic [7:0]  dbg_data;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        busy;

    modport slave (
        input  cpu_req, cpu_addr, romsel_we, romsel_din, dbg_req, dbg_addr, rom_data,
        output cpu_ack, cpu_data, romsel, dbg_ack, dbg_data, rom_addr, busy
    );

    modport master (
        output cpu_req, cpu_addr, romsel_we, romsel_din, dbg_req, dbg_addr, rom_data,
        input  cpu_ack, cpu_data, romsel, dbg_ack, dbg_data, rom_addr, busy
    );

endinterface

// File: rtl/rom_access_scheduler.sv
// rtl/rom_access_scheduler.sv - round-robin CPU/debug read sequencer for the single-ported ROM set
module rom_access_scheduler
    import rom_access_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    rom_access_scheduler_if.slave bus
);

    state_t      state;
    grant_t      last_grant;
    grant_t      pick;
    logic [17:0] rom_addr_q;
    logic        cpu_ack_q;
    logic        dbg_ack_q;
    logic [7:0]  cpu_data_q;
    logic [7:0]  dbg_data_q;
    logic [3:0]  romsel_q;
    logic        busy_q;

    // last_grant also names the port that owns the transaction in flight.
    always_comb begin
        pick = DBG;
        if (bus.cpu_req && (!bus.dbg_req || last_grant == DBG)) begin
            pick = CPU;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= DBG;
            rom_addr_q <= 18'h0;
            cpu_ack_q  <= 1'b0;
            dbg_ack_q  <= 1'b0;
            cpu_data_q <= DATA_RESET;
            dbg_data_q <= DATA_RESET;
            romsel_q   <= ROMSEL_RESET;
            busy_q     <= 1'b0;
        end else begin
            if (bus.romsel_we) begin
                romsel_q <= bus.romsel_din;
            end
            case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.dbg_req) begin
                        rom_addr_q <= (pick == CPU) ? map_cpu_addr(bus.cpu_addr, romsel_q)
                                                    : bus.dbg_addr;
                        last_grant <= pick;
                        busy_q     <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: state <= READ;
                READ: begin
                    if (last_grant == CPU) begin
                        cpu_data_q <= bus.rom_data;
                        cpu_ack_q  <= 1'b1;
                    end else begin
                        dbg_data_q <= bus.rom_data;
                        dbg_ack_q  <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    cpu_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.dbg_ack  = dbg_ack_q;
    assign bus.cpu_data = cpu_data_q;
    assign bus.dbg_data = dbg_data_q;
    assign bus.romsel   = romsel_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/rom_access_scheduler.md
# rom_access_scheduler

Sequences single-ported reads of the minimal Model B ROM set (18-bit address, one-cycle registered read, combinational bank select) and shares that port between the CPU fetch path and a debug/loader port. Owns the paged-ROM select register (ROMSEL), maps CPU addresses &8000–&FFFF onto ROM-set banks, and returns read data with a one-cycle acknowledge per transaction. Sits between the 6502 bus decode and the ROM set.

## Interface
- No parameters.
- clk  in  1  system clock; the only clock
- reset_n  in  1  reset, asynchronous assert, active-low
- cpu_req  in  1  CPU read request; held with cpu_addr until cpu_ack
- cpu_addr  in  16  CPU byte address
- cpu_ack  out  1  one-cycle pulse: cpu_data valid
- cpu_data  out  8  CPU read data, held until next CPU ack
- romsel_we  in  1  write strobe for ROMSEL (&FE30 decode done upstream)
- romsel_din  in  4  new ROMSEL value
- romsel  out  4  current paged-ROM bank
- dbg_req  in  1  debug read request; held with dbg_addr until dbg_ack
- dbg_addr  in  18  raw ROM-set address
- dbg_ack  out  1  one-cycle pulse: dbg_data valid
- dbg_data  out  8  debug read data, held until next debug ack
- rom_addr  out  18  address to ROM set; registered
- rom_data  in  8  ROM set data (valid one cycle after rom_addr, while rom_addr held)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ADDR, READ, DONE.
- IDLE: if any request pending, grant one, latch mapped address into rom_addr, go ADDR. Else stay.
- ADDR -> READ unconditionally (ROM set performs its registered read at end of ADDR).
- READ: rom_data valid; register it into the granted port's data output, raise that port's ack; go DONE.
- DONE: ack high this cycle only; -> IDLE. rom_addr held from ADDR through DONE.
- Arbitration: two-way round-robin. Only one pending: grant it. Both pending: grant the port not granted last; last_grant resets to DBG so CPU wins the first tie.
- CPU mapping: cpu_addr[15:14]=11 -> {4'h4, cpu_addr[13:0]} (MOS); =10 -> {romsel, cpu_addr[13:0]}. cpu_addr < &8000: not a ROM access; transaction still runs full sequence, rom_addr = {4'h0, cpu_addr[13:0]}, and the ROM set returns 8'hFF (unmapped bank) — no special case.
- Debug address passed through unmodified.
- ROMSEL: romsel_we loads romsel_din at next edge, any state. Mapping uses romsel value at the IDLE->ADDR edge; a write during ADDR/READ/DONE affects the next transaction only. Write coincident with grant: old value used.
- Requester dropping req before ack: transaction completes, ack still pulses, data still updates.
- Requester still high after ack: treated as a new request in the following IDLE cycle.

## Timing
- Reset values: state IDLE, rom_addr 0, cpu_ack 0, dbg_ack 0, cpu_data 8'hFF, dbg_data 8'hFF, romsel 4'hF, busy 0, last_grant DBG.
- Reset mid-transaction: all of the above immediately; no ack issued for the aborted read.
- Latency: request sampled high at edge k (in IDLE) -> ack high in cycle after edge k+2, i.e. ack visible 3 edges after sampling.
- Throughput: one transaction per 4 cycles (IDLE is one cycle between transactions).
- Both requesters continuously high: grants alternate CPU, DBG, CPU, ...; each port acked every 8 cycles.

## Structure
- Shared package: state enum (IDLE, ADDR, READ, DONE), grant enum (CPU, DBG), constants MOS_BANK = 4'h4, ROMSEL_RESET = 4'hF, DATA_RESET = 8'hFF, and a pure function mapping {cpu_addr, romsel} to 18-bit ROM address.
- No sub-module; single module. Bench instantiates the real ROM set with known .dat images.

## Test plan
- Reset, CPU read &C000 -> rom_addr 18'h10000, cpu_ack 3 edges after sample, cpu_data = os12 byte 0; romsel = F.
- romsel_we with 4'hE, CPU read &8003 -> rom_addr 18'h38003, data = mmfs byte 3; repeat with ROMSEL F -> basic byte 3.
- CPU and DBG both requesting continuously (cpu &FFFC, dbg 18'h3C000) -> grants CPU, DBG, CPU, DBG; each ack every 8 cycles, correct data to each port, other port's data unchanged.
- romsel_we to 4'hE asserted during ADDR of a CPU &8000 read with ROMSEL F -> that read returns basic byte 0; next read returns mmfs byte 0.
- CPU read &1234 -> cpu_data 8'hFF after normal latency; debug read 18'h00000 -> dbg_data 8'hFF.
- reset_n low during READ -> no ack, all outputs at reset values asynchronously; after release, fresh CPU read completes normally.
